// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared widths and the VRF read command type
package ara_pkg;

    // Wide enough for any vector length in elements this datapath supports.
    localparam int unsigned VlWidth    = 16;
    // Lane-local VRF address of one 64-bit word.
    localparam int unsigned VaddrWidth = 16;

    // eew is log2 of the element size in bytes.
    typedef struct packed {
        logic [4:0]         vs;
        logic [VlWidth-1:0] vl;
        logic [1:0]         eew;
    } vrf_rd_cmd_t;

endpackage

// File: rtl/vrf_read_issuer.sv
// rtl/vrf_read_issuer.sv - credit-gated sequencer of lane-local VRF word reads
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cmd_i/cmd_valid_i   read command {vs, vl, eew}; accepted when cmd_ready_o
//   vrf_req_o/addr_o    VRF read request and 64-bit word address
//   vrf_gnt_i           bank arbiter grant for the current request
//   operand_issued_o    one pulse per granted read, toward the operand queue
//   operand_consumed_i  operand queue popped one element (returns a credit)
//   busy_o              a command is in flight
module vrf_read_issuer
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes      = 4,
    parameter int unsigned VLEN         = 4096,
    parameter int unsigned DataBufDepth = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  vrf_rd_cmd_t           cmd_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    output logic                  vrf_req_o,
    output logic [VaddrWidth-1:0] vrf_addr_o,
    input  logic                  vrf_gnt_i,
    output logic                  operand_issued_o,
    input  logic                  operand_consumed_i,
    output logic                  busy_o
);

    localparam int unsigned WordsPerReg = VLEN / NrLanes / 64;
    localparam int unsigned LaneShift   = $clog2(8 * NrLanes);
    // vl << 3 plus the rounding addend needs four bits beyond vl.
    localparam int unsigned CntWidth    = VlWidth + 4;
    localparam int unsigned CreditWidth = $clog2(DataBufDepth + 1);
    localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(DataBufDepth);

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } state_e;

    state_e                 state_q, state_d;
    vrf_rd_cmd_t            cmd_q, cmd_d;
    logic [CntWidth-1:0]    word_idx_q, word_idx_d;
    logic [CreditWidth-1:0] credit_q, credit_d;

    logic                   grant;
    logic [CntWidth-1:0]    num_words_q;

    // Number of lane-local 64-bit words covering vl elements striped over
    // all lanes; NrLanes is a power of two so the division is a shift.
    function automatic logic [CntWidth-1:0] word_count(input vrf_rd_cmd_t c);
        logic [CntWidth-1:0] bytes;
        bytes = CntWidth'(c.vl) << c.eew;
        return (bytes + CntWidth'(8 * NrLanes - 1)) >> LaneShift;
    endfunction

    assign num_words_q = word_count(cmd_q);

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        word_idx_d       = word_idx_q;
        credit_d         = credit_q;
        cmd_ready_o      = 1'b0;
        vrf_req_o        = 1'b0;
        grant            = 1'b0;
        operand_issued_o = 1'b0;
        busy_o           = (state_q == ISSUE);
        vrf_addr_o       = VaddrWidth'(cmd_q.vs) * VaddrWidth'(WordsPerReg)
                         + VaddrWidth'(word_idx_q);

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                // A zero-length command is consumed without leaving IDLE.
                if (cmd_valid_i && (word_count(cmd_i) != '0)) begin
                    cmd_d      = cmd_i;
                    word_idx_d = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                vrf_req_o        = (credit_q != '0);
                grant            = vrf_req_o && vrf_gnt_i;
                operand_issued_o = grant;
                if (grant) begin
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == num_words_q - 1'b1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Grant takes a credit, consume returns one; both together cancel.
        // A grant implies credit != 0, so the decrement cannot wrap.
        if (grant && !operand_consumed_i) begin
            credit_d = credit_q - 1'b1;
        end else if (!grant && operand_consumed_i && (credit_q != CreditMax)) begin
            credit_d = credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            word_idx_q <= '0;
            credit_q   <= CreditMax;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            word_idx_q <= word_idx_d;
            credit_q   <= credit_d;
        end
    end

    // The operand queue can never pop more than was issued to it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(operand_consumed_i && (credit_q == CreditMax)))
                else $error("vrf_read_issuer: consume with full credit");
        end
    end

endmodule

// File: tb/tb_vrf_read_issuer.sv
// tb/tb_vrf_read_issuer.sv - self-checking bench for vrf_read_issuer
module tb_vrf_read_issuer;
    import ara_pkg::*;

    localparam int NR_LANES = 4;
    localparam int VLEN_B   = 4096;
    localparam int DEPTH    = 2;
    localparam int WPR      = VLEN_B / NR_LANES / 64;

    logic                  clk = 1'b0;
    logic                  rst;
    vrf_rd_cmd_t           cmd;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  vrf_req;
    logic [VaddrWidth-1:0] vrf_addr;
    logic                  gnt;
    logic                  issued;
    logic                  consumed;
    logic                  busy;

    always #5 clk = ~clk;

    vrf_read_issuer #(
        .NrLanes     (NR_LANES),
        .VLEN        (VLEN_B),
        .DataBufDepth(DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_i             (cmd),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .vrf_req_o         (vrf_req),
        .vrf_addr_o        (vrf_addr),
        .vrf_gnt_i         (gnt),
        .operand_issued_o  (issued),
        .operand_consumed_i(consumed),
        .busy_o            (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of word addresses still to be read plus a
    // credit count, i.e. free slots in the operand queue.
    bit m_busy;
    int m_credit;
    int m_addrs[$];
    int obs_addrs[$];

    typedef struct {
        int vs;
        int vl;
        int eew;
        int exp_words;
        int exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic set_cmd(input int vs, input int vl, input int eew);
        cmd.vs    = 5'(vs);
        cmd.vl    = VlWidth'(vl);
        cmd.eew   = 2'(eew);
        cmd_valid = 1'b1;
    endtask

    // One clock: inputs are already settled; compare mid-cycle, then advance.
    task automatic run_cycle(input bit g, input bit c, input bit r);
        bit exp_req;
        bit exp_iss;
        bit accept;
        int bytes;
        int words;
        gnt      = g;
        consumed = c;
        rst      = r;
        @(negedge clk);
        exp_req = m_busy && (m_credit > 0);
        exp_iss = exp_req && g;
        check("cmd_ready", cmd_ready, !m_busy);
        check("vrf_req", vrf_req, exp_req);
        check("operand_issued", issued, exp_iss);
        check("busy", busy, m_busy);
        if (exp_req) check("vrf_addr", vrf_addr, m_addrs[0]);
        if (issued === 1'b1) obs_addrs.push_back(int'(vrf_addr));
        accept = !m_busy && cmd_valid;
        if (r) begin
            m_busy   = 0;
            m_credit = DEPTH;
            m_addrs.delete();
        end else begin
            if (exp_iss) begin
                void'(m_addrs.pop_front());
                if (m_addrs.size() == 0) m_busy = 0;
            end
            m_credit = m_credit - int'(exp_iss) + int'(c);
            if (accept) begin
                bytes = int'(cmd.vl) * (1 << cmd.eew);
                words = (bytes + 8 * NR_LANES - 1) / (8 * NR_LANES);
                for (int k = 0; k < words; k++) m_addrs.push_back(int'(cmd.vs) * WPR + k);
                if (words > 0) m_busy = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Grant always, pop whenever a slot is occupied, until idle with full credit.
    task automatic drain();
        int i;
        i = 0;
        while ((m_busy || m_credit < DEPTH) && i < 200) begin
            run_cycle(1'b1, m_credit < DEPTH, 1'b0);
            i++;
        end
        check("drain_done", m_busy || (m_credit < DEPTH), 0);
    endtask

    task automatic accept_cmd(input int vs, input int vl, input int eew);
        set_cmd(vs, vl, eew);
        run_cycle(1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{vs: 3,  vl: 17, eew: 2, exp_words: 3,  exp_first: 48};
        vecs[1] = '{vs: 0,  vl: 64, eew: 3, exp_words: 16, exp_first: 0};
        vecs[2] = '{vs: 31, vl: 1,  eew: 0, exp_words: 1,  exp_first: 496};
        vecs[3] = '{vs: 5,  vl: 33, eew: 0, exp_words: 2,  exp_first: 80};
        vecs[4] = '{vs: 7,  vl: 8,  eew: 3, exp_words: 2,  exp_first: 112};
        vecs[5] = '{vs: 10, vl: 16, eew: 1, exp_words: 1,  exp_first: 160};
        vecs[6] = '{vs: 2,  vl: 0,  eew: 1, exp_words: 0,  exp_first: 0};

        cmd       = '0;
        cmd_valid = 1'b0;
        gnt       = 1'b0;
        consumed  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        m_busy   = 0;
        m_credit = DEPTH;

        // Reset state.
        check("reset_addr", vrf_addr, 0);
        run_cycle(1'b1, 1'b0, 1'b0);

        // Table: word count, address base and contiguity.
        foreach (vecs[v]) begin
            obs_addrs.delete();
            accept_cmd(vecs[v].vs, vecs[v].vl, vecs[v].eew);
            drain();
            check($sformatf("vec%0d_words", v), obs_addrs.size(), vecs[v].exp_words);
            foreach (obs_addrs[k])
                check($sformatf("vec%0d_addr%0d", v, k), obs_addrs[k], vecs[v].exp_first + k);
            check($sformatf("vec%0d_ready_after", v), cmd_ready, 1);
        end

        // Credit exhaustion: two reads go out, the third waits on a consume.
        obs_addrs.delete();
        accept_cmd(3, 17, 2);
        repeat (6) run_cycle(1'b1, 1'b0, 1'b0);
        check("stall_issued", obs_addrs.size(), 2);
        check("stall_req", vrf_req, 0);
        check("stall_addr", vrf_addr, 50);
        run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check("resume_issued", obs_addrs.size(), 3);
        check("resume_addr", obs_addrs[obs_addrs.size() - 1], 50);
        drain();

        // Zero-length command followed immediately by a real one.
        accept_cmd(9, 0, 2);
        check("vl0_busy", busy, 0);
        check("vl0_ready", cmd_ready, 1);
        obs_addrs.delete();
        accept_cmd(1, 8, 2);
        drain();
        check("after_vl0_words", obs_addrs.size(), 1);
        check("after_vl0_addr", obs_addrs[0], 16);

        // Grant withheld for five cycles mid-command.
        obs_addrs.delete();
        accept_cmd(4, 64, 1);
        run_cycle(1'b1, 1'b0, 1'b0);
        repeat (5) run_cycle(1'b0, m_credit < DEPTH, 1'b0);
        check("nogrant_issued", obs_addrs.size(), 1);
        check("nogrant_addr", vrf_addr, 65);
        drain();
        check("nogrant_words", obs_addrs.size(), 4);
        foreach (obs_addrs[k]) check($sformatf("nogrant_addr%0d", k), obs_addrs[k], 64 + k);

        // Reset during the second word of a 16-word command.
        accept_cmd(6, 64, 3);
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1);
        obs_addrs.delete();
        repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
        check("rst_no_reqs", obs_addrs.size(), 0);
        check("rst_idle", busy, 0);
        // Full credit after reset: exactly DEPTH reads go out with no consume.
        accept_cmd(0, 128, 3);
        repeat (5) run_cycle(1'b1, 1'b0, 1'b0);
        check("rst_credit", obs_addrs.size(), DEPTH);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (!m_busy && ($urandom_range(0, 2) == 0))
                set_cmd($urandom_range(0, 31), $urandom_range(0, 96), $urandom_range(0, 3));
            run_cycle($urandom_range(0, 1) == 1,
                      ($urandom_range(0, 1) == 1) && (m_credit < DEPTH), 1'b0);
            cmd_valid = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
